// File: rtl/wb_stage_regfile.sv
// ============================================================================
//  Module  : wb_stage_regfile
//  Brief   : Writeback stage plus 32-entry register file with bypass, PC
//            redirect and retired-instruction counter.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module wb_stage_regfile #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int CNT_W = 64
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             valid_i,
  input  logic [XLEN-1:0]  pcNext_i,
  input  logic [XLEN-1:0]  pcIn_i,
  input  logic [XLEN-1:0]  valueplusImm_i,
  input  logic [XLEN-1:0]  pcplusImm_i,
  input  logic [XLEN-1:0]  ALUResult_i,
  input  logic [XLEN-1:0]  memWrite_out2_i,
  input  logic [4:0]       rd_i,
  input  logic             pcBranch_i,
  input  logic             RegWrite_i,
  input  logic             Con_Jalr_i,
  input  logic             LoadMux_i,
  input  logic             link_i,
  input  logic [4:0]       rs1_addr_i,
  input  logic [4:0]       rs2_addr_i,
  output logic [XLEN-1:0]  rs1_data_o,
  output logic [XLEN-1:0]  rs2_data_o,
  output logic             redirect_o,
  output logic [XLEN-1:0]  redirect_pc_o,
  output logic [CNT_W-1:0] retired_o
);

  localparam int c_AW = $clog2(NREGS);

  logic [XLEN-1:0]  r_regs [NREGS];
  logic             r_redirect;
  logic [XLEN-1:0]  r_redirect_pc;
  logic [CNT_W-1:0] r_retired;

  logic             w_commit;
  logic             w_take;
  logic [XLEN-1:0]  w_wb_data;
  logic [XLEN-1:0]  w_target;
  logic             w_unused;

  // pcIn_i and the jalr target LSB are intentionally not consumed.
  assign w_unused = ^{pcIn_i, valueplusImm_i[0]};

  assign w_commit = valid_i & RegWrite_i & (rd_i != 5'd0);
  assign w_take   = valid_i & (pcBranch_i | Con_Jalr_i);

  always_comb begin
    w_wb_data = ALUResult_i;
    if (link_i)
      w_wb_data = pcNext_i;
    else if (LoadMux_i)
      w_wb_data = memWrite_out2_i;
  end

  always_comb begin
    w_target = pcplusImm_i;
    if (Con_Jalr_i)
      w_target = {valueplusImm_i[XLEN-1:1], 1'b0};
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < NREGS; i++)
        r_regs[i] <= '0;
    end else if (w_commit) begin
      r_regs[rd_i[c_AW-1:0]] <= w_wb_data;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_redirect    <= 1'b0;
      r_redirect_pc <= '0;
      r_retired     <= '0;
    end else begin
      r_redirect <= w_take;
      if (w_take)
        r_redirect_pc <= w_target;
      if (valid_i)
        r_retired <= r_retired + CNT_W'(1);
    end
  end

  // Same-cycle bypass lets decode see the value being committed this edge.
  always_comb begin
    rs1_data_o = r_regs[rs1_addr_i[c_AW-1:0]];
    if (rs1_addr_i == 5'd0)
      rs1_data_o = '0;
    else if (w_commit && (rd_i == rs1_addr_i))
      rs1_data_o = w_wb_data;
  end

  always_comb begin
    rs2_data_o = r_regs[rs2_addr_i[c_AW-1:0]];
    if (rs2_addr_i == 5'd0)
      rs2_data_o = '0;
    else if (w_commit && (rd_i == rs2_addr_i))
      rs2_data_o = w_wb_data;
  end

  assign redirect_o    = r_redirect;
  assign redirect_pc_o = r_redirect_pc;
  assign retired_o     = r_retired;

  a_link_load_excl: assert property (@(posedge clk_i) disable iff (reset_i)
    !(valid_i && link_i && LoadMux_i));

endmodule

`default_nettype wire

// File: tb/tb_wb_stage_regfile.sv
// ============================================================================
//  Module  : tb_wb_stage_regfile
//  Brief   : Directed self-checking bench for wb_stage_regfile.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_wb_stage_regfile;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        valid_i, pcBranch_i, RegWrite_i, Con_Jalr_i, LoadMux_i, link_i;
  logic [31:0] pcNext_i, pcIn_i, valueplusImm_i, pcplusImm_i, ALUResult_i, memWrite_out2_i;
  logic [4:0]  rd_i, rs1_addr_i, rs2_addr_i;

  logic [31:0] rs1_data_o, rs2_data_o, redirect_pc_o;
  logic        redirect_o;
  logic [63:0] retired_o;

  logic [31:0] w4_rs1, w4_rs2, w4_pc;
  logic        w4_redirect;
  logic [3:0]  w4_retired;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_i = ~clk_i;

  wb_stage_regfile #(.XLEN(32), .NREGS(32), .CNT_W(64)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .valid_i(valid_i), .pcNext_i(pcNext_i),
    .pcIn_i(pcIn_i), .valueplusImm_i(valueplusImm_i), .pcplusImm_i(pcplusImm_i),
    .ALUResult_i(ALUResult_i), .memWrite_out2_i(memWrite_out2_i), .rd_i(rd_i),
    .pcBranch_i(pcBranch_i), .RegWrite_i(RegWrite_i), .Con_Jalr_i(Con_Jalr_i),
    .LoadMux_i(LoadMux_i), .link_i(link_i), .rs1_addr_i(rs1_addr_i),
    .rs2_addr_i(rs2_addr_i), .rs1_data_o(rs1_data_o), .rs2_data_o(rs2_data_o),
    .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o), .retired_o(retired_o)
  );

  wb_stage_regfile #(.XLEN(32), .NREGS(32), .CNT_W(4)) dut4 (
    .clk_i(clk_i), .reset_i(reset_i), .valid_i(valid_i), .pcNext_i(pcNext_i),
    .pcIn_i(pcIn_i), .valueplusImm_i(valueplusImm_i), .pcplusImm_i(pcplusImm_i),
    .ALUResult_i(ALUResult_i), .memWrite_out2_i(memWrite_out2_i), .rd_i(rd_i),
    .pcBranch_i(pcBranch_i), .RegWrite_i(RegWrite_i), .Con_Jalr_i(Con_Jalr_i),
    .LoadMux_i(LoadMux_i), .link_i(link_i), .rs1_addr_i(rs1_addr_i),
    .rs2_addr_i(rs2_addr_i), .rs1_data_o(w4_rs1), .rs2_data_o(w4_rs2),
    .redirect_o(w4_redirect), .redirect_pc_o(w4_pc), .retired_o(w4_retired)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    valid_i = 0; pcBranch_i = 0; RegWrite_i = 0; Con_Jalr_i = 0;
    LoadMux_i = 0; link_i = 0; rd_i = 0;
  endtask

  initial begin
    reset_i = 1; idle();
    pcNext_i = 0; pcIn_i = 0; valueplusImm_i = 0; pcplusImm_i = 0;
    ALUResult_i = 0; memWrite_out2_i = 0; rs1_addr_i = 0; rs2_addr_i = 0;
    tick(); tick();
    reset_i = 0;
    tick();

    // Preload x5 so the reset clear is observable.
    valid_i = 1; RegWrite_i = 1; rd_i = 5; ALUResult_i = 32'h1234; rs1_addr_i = 5;
    tick();
    idle();
    #1 check("x5_pre", rs1_data_o, 32'h1234);
    check("ret_pre", retired_o, 1);
    #2 reset_i = 1;
    #1 check("rst_x5", rs1_data_o, 0);
    check("rst_ret", retired_o, 0);
    check("rst_redir", redirect_o, 0);
    check("rst_rpc", redirect_pc_o, 0);
    tick();
    reset_i = 0;
    tick();

    // ALU writeback with dual bypass.
    valid_i = 1; RegWrite_i = 1; rd_i = 7; ALUResult_i = 32'hDEADBEEF;
    rs1_addr_i = 7; rs2_addr_i = 7;
    #1 check("alu_byp1", rs1_data_o, 32'hDEADBEEF);
    check("alu_byp2", rs2_data_o, 32'hDEADBEEF);
    tick();
    idle();
    #1 check("alu_stored", rs1_data_o, 32'hDEADBEEF);
    check("alu_ret", retired_o, 1);

    // Load, then dropped write to x0.
    valid_i = 1; RegWrite_i = 1; LoadMux_i = 1; memWrite_out2_i = 32'hFF;
    ALUResult_i = 32'h99; rd_i = 3; rs1_addr_i = 3;
    tick();
    LoadMux_i = 0; rd_i = 0; ALUResult_i = 5; rs1_addr_i = 0; rs2_addr_i = 3;
    #1 check("x0_byp", rs1_data_o, 0);
    check("load_x3", rs2_data_o, 32'hFF);
    tick();
    idle();
    #1 check("x0_read", rs1_data_o, 0);
    check("x0_ret", retired_o, 3);

    // jalr with link, all control flags set.
    valid_i = 1; RegWrite_i = 1; Con_Jalr_i = 1; link_i = 1; pcBranch_i = 1;
    valueplusImm_i = 32'h1003; pcplusImm_i = 32'h2000; pcNext_i = 32'h104;
    rd_i = 1; rs1_addr_i = 1;
    #1 check("jalr_pre_redir", redirect_o, 0);
    tick();
    idle();
    #1 check("jalr_redir", redirect_o, 1);
    check("jalr_pc", redirect_pc_o, 32'h1002);
    check("jalr_link", rs1_data_o, 32'h104);
    check("jalr_ret", retired_o, 4);
    tick();
    check("jalr_pulse_end", redirect_o, 0);
    check("jalr_pc_hold", redirect_pc_o, 32'h1002);

    // Bubble must not write, redirect or count.
    valid_i = 0; RegWrite_i = 1; rd_i = 9; ALUResult_i = 32'h77; pcBranch_i = 1;
    pcplusImm_i = 32'h500; rs1_addr_i = 9;
    #1 check("bub_nobyp", rs1_data_o, 0);
    tick();
    check("bub_redir", redirect_o, 0);
    check("bub_ret", retired_o, 4);
    check("bub_nowrite", rs1_data_o, 0);

    // Back-to-back taken branches.
    idle();
    valid_i = 1; pcBranch_i = 1; pcplusImm_i = 32'h40;
    tick();
    check("br1_redir", redirect_o, 1);
    check("br1_pc", redirect_pc_o, 32'h40);
    tick();
    idle();
    #1 check("br2_redir", redirect_o, 1);
    check("br2_pc", redirect_pc_o, 32'h40);
    tick();
    check("br_end", redirect_o, 0);
    check("br_ret", retired_o, 6);

    // Reset mid-stream cancels a pending redirect.
    valid_i = 1; pcBranch_i = 1; pcplusImm_i = 32'h80;
    tick();
    idle();
    check("mid_redir_pre", redirect_o, 1);
    #2 reset_i = 1;
    #1 check("mid_redir", redirect_o, 0);
    check("mid_ret", retired_o, 0);
    #2 reset_i = 0;
    valid_i = 1; RegWrite_i = 1; rd_i = 2; ALUResult_i = 32'h55; rs1_addr_i = 2;
    tick();
    idle();
    #1 check("post_rst_x2", rs1_data_o, 32'h55);
    check("post_rst_ret", retired_o, 1);

    // Counter wrap on the 4-bit instance.
    reset_i = 1;
    #2 reset_i = 0;
    check("wrap_start", w4_retired, 0);
    valid_i = 1;
    for (int i = 0; i < 15; i++) tick();
    check("wrap_15", w4_retired, 15);
    tick();
    idle();
    #1 check("wrap_0", w4_retired, 0);
    check("wrap_wide", retired_o, 16);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/wb_stage_regfile.md
Name: wb_stage_regfile

Overview:
- Consumer end of the MEM/WB pipeline register.
- Selects the writeback value and commits it to a 32-entry integer register file, which the decode stage reads through two read ports with write-through bypass.
- Produces the registered PC redirect for taken branches and jumps.
- Counts retired instructions.

Parameters:
XLEN, 32, datapath width
NREGS, 32, architectural register count (index width = $clog2(NREGS))
CNT_W, 64, retired-instruction counter width

Ports:
clk_i  in  1  clock, all state on rising edge
reset_i  in  1  asynchronous, active-high reset
valid_i  in  1  MEM/WB slot holds a real instruction (0 = bubble)
pcNext_i  in  XLEN  pc+4 of the instruction (link value)
pcIn_i  in  XLEN  pc of the instruction
valueplusImm_i  in  XLEN  rs1+imm (jalr target before LSB clear)
pcplusImm_i  in  XLEN  pc+imm (branch/jal target)
ALUResult_i  in  XLEN  ALU result
memWrite_out2_i  in  XLEN  load data from data memory
rd_i  in  5  destination register
pcBranch_i  in  1  branch taken or jal
RegWrite_i  in  1  write rd
Con_Jalr_i  in  1  instruction is jalr
LoadMux_i  in  1  writeback selects load data
link_i  in  1  writeback selects pcNext_i (jal/jalr)
rs1_addr_i  in  5  read port 1 address
rs2_addr_i  in  5  read port 2 address
rs1_data_o  out  XLEN  read port 1 data
rs2_data_o  out  XLEN  read port 2 data
redirect_o  out  1  registered PC redirect strobe
redirect_pc_o  out  XLEN  registered redirect target
retired_o  out  CNT_W  retired-instruction count

Behaviour:
- Reset (async, immediate on reset_i=1):
  - All registers x0..x31 = 0.
  - redirect_o = 0, redirect_pc_o = 0, retired_o = 0.
  - Read outputs reflect zeroed registers combinationally.
- Commit: commit = valid_i & RegWrite_i & (rd_i != 0).
- Writeback data priority:
  - link_i: pcNext_i
  - else LoadMux_i: memWrite_out2_i
  - else: ALUResult_i
- Register write occurs on the rising edge when commit=1.
- x0 reads 0 always; a write to x0 is dropped and the instruction still counts as retired.
- Read ports are combinational: rsN_data_o = 0 if addr=0; else wb data if commit & rd_i==addr (same-cycle bypass); else stored value.
- Both ports may bypass simultaneously.
- Redirect (1-cycle registered latency):
  - Next-cycle redirect_o = valid_i & (pcBranch_i | Con_Jalr_i).
  - Target: Con_Jalr_i -> {valueplusImm_i[XLEN-1:1],1'b0}; else pcplusImm_i.
  - Con_Jalr_i has priority when both are set.
  - redirect_o is a single-cycle pulse per qualifying instruction; back-to-back qualifying instructions give consecutive pulses.
  - redirect_pc_o holds its last value when redirect_o=0.
- Retire counter:
  - Increments by 1 on each edge with valid_i=1, regardless of RegWrite_i.
  - Wraps from all-ones to 0 with no flag.
- Bubbles (valid_i=0):
  - Never write, never redirect, never count.
  - Other inputs are don't-care.
- Reset asserted mid-stream:
  - Pending redirect is cancelled and state is cleared.
  - First edge after deassertion behaves normally.
- pcIn_i is unused except for trace/assertion hooks.
- Assertion: link_i & LoadMux_i never both 1 when valid_i=1.

Test Plan:
- Reset: hold reset_i=1 mid-cycle with x5 previously written 0x1234 -> rs1_data_o(x5)=0 immediately; retired_o=0; redirect_o=0.
- ALU writeback: valid=1, RegWrite=1, rd=7, ALUResult=0xDEADBEEF, rs1_addr=7 same cycle -> rs1_data_o=0xDEADBEEF via bypass; after edge rs1_data_o still 0xDEADBEEF; retired_o=1.
- Load vs. x0: LoadMux=1, mem=0x0000_00FF, rd=3 -> x3=0xFF. Then rd=0, ALUResult=5 -> x0 reads 0 and retired_o increments.
- jalr: valid=1, Con_Jalr=1, link=1, pcBranch=1, valueplusImm=0x1003, pcplusImm=0x2000, pcNext=0x104, rd=1 -> next cycle redirect_o=1 with redirect_pc_o=0x1002 (one cycle only); x1=0x104.
- Bubble/branch: valid=0 with RegWrite=1, pcBranch=1 -> no write, no redirect, count unchanged. Then valid=1, pcBranch=1, pcplusImm=0x40 for two consecutive cycles -> two consecutive redirect pulses, both to 0x40.
- Counter wrap: CNT_W=4, 16 valid instructions from reset -> retired_o reaches 15 then 0.
